// File: rtl/sinx_pkg.sv
// Shared types and constants for the sin(x) accelerator feeder.
package sinx_pkg;
  localparam int SINX_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/sinx_feeder_if.sv
// Sample-in / core / result-out bundle of the sin(x) feeder; slave = feeder side.
interface sinx_feeder_if
  import sinx_pkg::*;
#(
  parameter int DATA_W = SINX_DATA_W
) ();
  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_x_i;
  logic              sinx_start_o;
  logic [DATA_W-1:0] sinx_x_o;
  logic [DATA_W-1:0] sinx_result_i;
  logic              sinx_done_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_result_o;

  modport slave (
    input  s_valid_i, s_x_i, sinx_result_i, sinx_done_i, m_ready_i,
    output s_ready_o, sinx_start_o, sinx_x_o, m_valid_o, m_result_o
  );

  modport master (
    output s_valid_i, s_x_i, sinx_result_i, sinx_done_i, m_ready_i,
    input  s_ready_o, sinx_start_o, sinx_x_o, m_valid_o, m_result_o
  );
endinterface

// File: rtl/sinx_res_fifo.sv
// Synchronous result FIFO with occupancy count; push when full and pop when empty are dropped.
module sinx_res_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_full, w_wr, w_rd;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push && !w_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count only.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/sinx_feeder.sv
// Streaming front-end for the sin(x) core: one job in flight, results buffered in a FIFO.
// Optional wait-timeout abort enabled by defining SINX_FEEDER_TIMEOUT_EN.
module sinx_feeder
  import sinx_pkg::*;
#(
  parameter int DATA_W      = SINX_DATA_W,
  parameter int OUT_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  sinx_feeder_if.slave bus,
  output logic [15:0]  jobs_o,
  output logic         err_o
);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sinx_feeder: OUT_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("sinx_feeder: TIMEOUT_CYC must fit the 8-bit wait counter");
  end

  feeder_state_t     r_state, w_state_nxt;
  logic [DATA_W-1:0] r_x_q, w_push_data, w_fifo_data;
  logic [15:0]       r_jobs;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic              w_fifo_empty, w_s_ready, w_accept, w_start, w_push, w_pop;

`ifdef SINX_FEEDER_TIMEOUT_EN
  logic [7:0] r_wcnt;
  logic       r_err, w_to_hit, w_to;

  // Hit on the last allowed WAIT cycle, so the abort edge is where the count reaches TIMEOUT_CYC.
  assign w_to_hit = (r_wcnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == START)     r_wcnt <= '0;
      else if (r_state == WAIT) r_wcnt <= r_wcnt + 8'd1;
      if (w_to) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_start     = 1'b0;
    w_push      = 1'b0;
    w_push_data = bus.sinx_result_i;
`ifdef SINX_FEEDER_TIMEOUT_EN
    w_to        = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_s_ready = (w_fifo_cnt < CNT_W'(OUT_DEPTH));
        if (bus.s_valid_i && w_s_ready) w_state_nxt = START;
      end
      START: begin
        w_start     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.sinx_done_i) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
`ifdef SINX_FEEDER_TIMEOUT_EN
        else if (w_to_hit) begin
          w_push      = 1'b1;
          w_push_data = {DATA_W{1'b1}};
          w_to        = 1'b1;
          w_state_nxt = IDLE;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    // Stream and core outputs stay quiet while reset is held.
    if (rst_i) begin
      w_s_ready = 1'b0;
      w_start   = 1'b0;
      w_push    = 1'b0;
    end
  end

  assign w_accept = bus.s_valid_i && w_s_ready;
  assign w_pop    = bus.m_valid_o && bus.m_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_x_q   <= '0;
      r_jobs  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_x_q <= bus.s_x_i;
      if (w_push)   r_jobs <= r_jobs + 16'd1;
    end
  end

  sinx_res_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty)
  );

  assign bus.s_ready_o    = w_s_ready;
  assign bus.sinx_start_o = w_start;
  assign bus.sinx_x_o     = r_x_q;
  assign bus.m_valid_o    = !w_fifo_empty && !rst_i;
  assign bus.m_result_o   = w_fifo_data;
  assign jobs_o           = r_jobs;
endmodule
